// File: rtl/mvm_scheduler_pkg.sv
// Shared types and sizing helpers for the MVM scheduler and its datapath.
package mvm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_X,
    MAC,
    WRITE,
    OUT_PRIME,
    OUT
  } state_t;

  localparam int K_DEF     = 4;
  localparam int B_DEF     = 8;
  localparam int G_DEF     = 0;
  localparam int LOG_A_DEF = 4;
  localparam int LOG_X_DEF = 2;

  // Cycles spent per row: K operand reads, one drain cycle, plus pipeline depth.
  function automatic int P_OF(input int k, input int g);
    return k + 1 + g;
  endfunction

  function automatic int cnt_w(input int k);
    return $clog2(k * k + 1);
  endfunction

endpackage

// File: rtl/mvm_scheduler_if.sv
// Command, input-stream and output-stream handshakes of the MVM scheduler.
interface mvm_scheduler_if;

  logic cmd_valid;
  logic cmd_reuse_a;
  logic cmd_ready;
  logic in_valid;
  logic in_ready;
  logic out_valid;
  logic out_last;
  logic out_ready;

  modport master (
    output cmd_valid, cmd_reuse_a, in_valid, out_ready,
    input  cmd_ready, in_ready, out_valid, out_last
  );

  modport slave (
    input  cmd_valid, cmd_reuse_a, in_valid, out_ready,
    output cmd_ready, in_ready, out_valid, out_last
  );

endinterface

// File: rtl/mvm_scheduler.sv
// Sequences the shared MVM datapath: load A/x, overlapped row MACs, then
// stream y out under backpressure. All outputs decode registered state.
module mvm_scheduler
  import mvm_pkg::*;
#(
  parameter int K     = K_DEF,
  parameter int B     = B_DEF,
  parameter int G     = G_DEF,
  parameter int LOG_A = LOG_A_DEF,
  parameter int LOG_X = LOG_X_DEF
) (
  input  logic             clk,
  input  logic             reset,
  mvm_scheduler_if.slave   hs,
  output logic [LOG_A-1:0] addr_a,
  output logic             wr_en_a,
  output logic [LOG_X-1:0] addr_x,
  output logic             wr_en_x,
  output logic [LOG_X-1:0] addr_y,
  output logic             wr_en_y,
  output logic             clear_acc,
  output logic             busy
);

  localparam int P  = P_OF(K, G);
  localparam int CW = cnt_w(K);

  localparam logic [CW-1:0] KK_M1 = CW'(K * K - 1);
  localparam logic [CW-1:0] K_M1  = CW'(K - 1);
  localparam logic [CW-1:0] P_M1  = CW'(P - 1);

  if (LOG_A < $clog2(K * K) || LOG_X < $clog2(K) || B < 1 || G < 0) begin : g_bad_params
    $error("mvm_scheduler: address widths too narrow or illegal B/G");
  end

  state_t        state_reg;
  logic [CW-1:0] idx_reg;
  logic [CW-1:0] row_reg;
  logic [CW-1:0] cyc_reg;
  logic [CW-1:0] oidx_reg;
  logic          a_loaded_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      idx_reg      <= '0;
      row_reg      <= '0;
      cyc_reg      <= '0;
      oidx_reg     <= '0;
      a_loaded_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (hs.cmd_valid) begin
            idx_reg   <= '0;
            row_reg   <= '0;
            cyc_reg   <= '0;
            oidx_reg  <= '0;
            state_reg <= (hs.cmd_reuse_a && a_loaded_reg) ? LOAD_X : LOAD_A;
          end
        end
        LOAD_A: begin
          if (hs.in_valid) begin
            if (idx_reg == KK_M1) begin
              idx_reg      <= '0;
              a_loaded_reg <= 1'b1;
              state_reg    <= LOAD_X;
            end else begin
              idx_reg <= idx_reg + 1'b1;
            end
          end
        end
        LOAD_X: begin
          if (hs.in_valid) begin
            if (idx_reg == K_M1) begin
              idx_reg   <= '0;
              state_reg <= MAC;
            end else begin
              idx_reg <= idx_reg + 1'b1;
            end
          end
        end
        MAC: begin
          if (cyc_reg == P_M1) begin
            cyc_reg <= '0;
            if (row_reg == K_M1) begin
              state_reg <= WRITE;
            end else begin
              row_reg <= row_reg + 1'b1;
            end
          end else begin
            cyc_reg <= cyc_reg + 1'b1;
          end
        end
        WRITE:     state_reg <= OUT_PRIME;
        OUT_PRIME: state_reg <= OUT;
        OUT: begin
          if (hs.out_ready) begin
            if (oidx_reg == K_M1) begin
              oidx_reg  <= '0;
              state_reg <= IDLE;
            end else begin
              oidx_reg <= oidx_reg + 1'b1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_comb begin
    hs.cmd_ready = 1'b0;
    hs.in_ready  = 1'b0;
    hs.out_valid = 1'b0;
    hs.out_last  = 1'b0;
    addr_a       = '0;
    wr_en_a      = 1'b0;
    addr_x       = '0;
    wr_en_x      = 1'b0;
    addr_y       = '0;
    wr_en_y      = 1'b0;
    clear_acc    = 1'b0;
    busy         = 1'b0;
    if (!reset) begin
      busy = (state_reg != IDLE);
      case (state_reg)
        IDLE: hs.cmd_ready = 1'b1;
        LOAD_A: begin
          hs.in_ready = 1'b1;
          wr_en_a     = hs.in_valid;
          addr_a      = LOG_A'(idx_reg);
        end
        LOAD_X: begin
          hs.in_ready = 1'b1;
          wr_en_x     = hs.in_valid;
          addr_x      = LOG_X'(idx_reg);
        end
        MAC: begin
          clear_acc = (cyc_reg == '0);
          if (int'(cyc_reg) < K) begin
            addr_a = LOG_A'(int'(row_reg) * K + int'(cyc_reg));
            addr_x = LOG_X'(cyc_reg);
          end
          // c0 of row r+1 commits row r while the accumulator restarts
          if (cyc_reg == '0 && row_reg != '0) begin
            wr_en_y = 1'b1;
            addr_y  = LOG_X'(int'(row_reg) - 1);
          end
        end
        WRITE: begin
          wr_en_y = 1'b1;
          addr_y  = LOG_X'(K - 1);
        end
        OUT_PRIME: addr_y = '0;
        OUT: begin
          hs.out_valid = 1'b1;
          hs.out_last  = (oidx_reg == K_M1);
          // Read one ahead on accept so data_out refreshes every cycle
          addr_y       = LOG_X'(int'(oidx_reg) + int'(hs.out_ready));
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mvm_scheduler.sv
// Directed bench: scheduler plus a behavioural datapath, G=0 and G=1 builds.
module tb_mvm_scheduler;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  int cmp_cnt = 0;
  int bad_cnt = 0;

  mvm_scheduler_if hs ();
  mvm_scheduler_if hs1 ();

  logic [3:0] addr_a;
  logic [1:0] addr_x, addr_y;
  logic       wr_en_a, wr_en_x, wr_en_y, clear_acc, busy;
  logic [7:0] data_in;

  logic [3:0] addr_a_g1;
  logic [1:0] addr_x_g1, addr_y_g1;
  logic       wr_en_a_g1, wr_en_x_g1, wr_en_y_g1, clear_acc_g1, busy_g1;

  mvm_scheduler #(.K(4), .B(8), .G(0), .LOG_A(4), .LOG_X(2)) dut (
    .clk(clk), .reset(reset), .hs(hs),
    .addr_a(addr_a), .wr_en_a(wr_en_a), .addr_x(addr_x), .wr_en_x(wr_en_x),
    .addr_y(addr_y), .wr_en_y(wr_en_y), .clear_acc(clear_acc), .busy(busy)
  );

  mvm_scheduler #(.K(4), .B(8), .G(1), .LOG_A(4), .LOG_X(2)) dut_g1 (
    .clk(clk), .reset(reset), .hs(hs1),
    .addr_a(addr_a_g1), .wr_en_a(wr_en_a_g1), .addr_x(addr_x_g1), .wr_en_x(wr_en_x_g1),
    .addr_y(addr_y_g1), .wr_en_y(wr_en_y_g1), .clear_acc(clear_acc_g1), .busy(busy_g1)
  );

  // Behavioural datapath for G=0: registered memory reads, MAC in the next cycle.
  logic signed [7:0]  mem_a [16];
  logic signed [7:0]  mem_x [4];
  logic signed [15:0] mem_y [4];
  logic signed [7:0]  a_q, x_q;
  logic signed [15:0] acc;
  logic [15:0]        data_out;

  always @(posedge clk) begin
    if (wr_en_a) mem_a[addr_a] <= data_in;
    if (wr_en_x) mem_x[addr_x] <= data_in;
    a_q <= mem_a[addr_a];
    x_q <= mem_x[addr_x];
    acc <= clear_acc ? 16'sd0 : acc + a_q * x_q;
    if (wr_en_y) mem_y[addr_y] <= acc;
    data_out <= mem_y[addr_y];
  end

  task automatic do_job(
    input  bit               reuse,
    input  logic [19:0][7:0] words,
    input  int               gap_pct,
    input  int               ready_mode,
    output logic [3:0][15:0] y,
    output logic [3:0]       lastv,
    output int               nwords,
    output int               lat,
    output int               job_cycles,
    output bit               stable_ok,
    output bit               cmd_rdy_busy,
    output bit               tmo
  );
    int n0, t_last, nout, stall_left, guard;
    bit done, held_v, first_seen;
    logic [15:0] held;
    y = '0; lastv = '0; nwords = 0; lat = -1; job_cycles = -1;
    stable_ok = 1'b1; cmd_rdy_busy = 1'b0; tmo = 1'b0;
    nout = 0; stall_left = 5; done = 1'b0; held_v = 1'b0; first_seen = 1'b0;
    t_last = 0; held = '0;
    @(negedge clk);
    hs.cmd_valid = 1'b1; hs.cmd_reuse_a = reuse; hs.in_valid = 1'b0; hs.out_ready = 1'b0;
    #1;
    guard = 0;
    while (!hs.cmd_ready && guard < 20) begin
      @(negedge clk); #1; guard++;
    end
    if (!hs.cmd_ready) begin
      tmo = 1'b1; hs.cmd_valid = 1'b0;
      return;
    end
    n0 = cyc_cnt;
    guard = 0;
    while (!done && guard < 400) begin
      @(negedge clk);
      guard++;
      hs.cmd_valid   = 1'b0;
      hs.cmd_reuse_a = 1'b0;
      hs.in_valid    = (nwords < 20) && (int'($urandom_range(99)) >= gap_pct);
      data_in        = (nwords < 20) ? words[nwords] : 8'h00;
      case (ready_mode)
        1:       hs.out_ready = !(nout == 2 && stall_left > 0);
        2:       hs.out_ready = guard[0];
        default: hs.out_ready = 1'b1;
      endcase
      #1;
      if (hs.cmd_ready) cmd_rdy_busy = 1'b1;
      if (hs.in_valid && hs.in_ready) begin
        nwords++;
        t_last = cyc_cnt;
      end
      if (hs.out_valid) begin
        if (!first_seen) begin
          first_seen = 1'b1;
          lat = cyc_cnt - t_last;
        end
        if (held_v && data_out !== held) stable_ok = 1'b0;
        if (hs.out_ready) begin
          if (nout < 4) begin
            y[nout]     = data_out;
            lastv[nout] = hs.out_last;
          end
          held_v = 1'b0;
          nout++;
          if (hs.out_last || nout >= 4) begin
            done = 1'b1;
            if (hs.out_last) job_cycles = cyc_cnt - n0 + 1;
          end
        end else begin
          held   = data_out;
          held_v = 1'b1;
          if (ready_mode == 1) stall_left--;
        end
      end
    end
    if (!done) tmo = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk); #1;
    cmp_cnt++;
    if ({hs.cmd_ready, hs.in_ready, hs.out_valid, hs.out_last, busy, clear_acc,
         wr_en_a, wr_en_x, wr_en_y, addr_a, addr_x, addr_y} !== '0) begin
      bad_cnt++;
      $display("FAIL reset_outputs: got nonzero outputs, busy=%b cmd_ready=%b, need all 0", busy, hs.cmd_ready);
    end
    reset = 1'b0;
    @(negedge clk); #1;
    cmp_cnt++;
    if (hs.cmd_ready !== 1'b1 || busy !== 1'b0 || hs.in_ready !== 1'b0 || hs.out_valid !== 1'b0) begin
      bad_cnt++;
      $display("FAIL idle_after_reset: cmd_ready=%b busy=%b in_ready=%b out_valid=%b, need 1 0 0 0",
               hs.cmd_ready, busy, hs.in_ready, hs.out_valid);
    end
    $display("test_reset: checked reset and idle outputs");
  endtask

  task automatic test_identity();
    logic [19:0][7:0] w;
    logic [3:0][15:0] y;
    logic [3:0] lastv;
    int nw, lat, jc;
    bit st, crb, tmo;
    logic [15:0] exp_y [4];
    for (int i = 0; i < 16; i++) w[i] = 8'(i + 1);
    for (int i = 0; i < 4; i++) w[16 + i] = 8'(i + 1);
    exp_y = '{16'd30, 16'd70, 16'd110, 16'd150};
    do_job(1'b0, w, 0, 0, y, lastv, nw, lat, jc, st, crb, tmo);
    cmp_cnt++;
    if (tmo) begin bad_cnt++; $display("FAIL identity_timeout: job did not complete"); end
    for (int i = 0; i < 4; i++) begin
      cmp_cnt++;
      if (y[i] !== exp_y[i]) begin
        bad_cnt++;
        $display("FAIL identity_y%0d: got %0d need %0d", i, y[i], exp_y[i]);
      end
    end
    cmp_cnt++;
    if (lastv !== 4'b1000) begin bad_cnt++; $display("FAIL identity_last: got %b need 1000", lastv); end
    cmp_cnt++;
    if (nw !== 20) begin bad_cnt++; $display("FAIL identity_words: got %0d need 20", nw); end
    cmp_cnt++;
    if (lat !== 23) begin bad_cnt++; $display("FAIL identity_latency: got %0d need 23", lat); end
    cmp_cnt++;
    if (jc !== 47) begin bad_cnt++; $display("FAIL identity_job_cycles: got %0d need 47", jc); end
    cmp_cnt++;
    if (crb) begin bad_cnt++; $display("FAIL identity_cmd_ready_busy: got 1 need 0"); end
    $display("test_identity: y=%0d,%0d,%0d,%0d lat=%0d cycles=%0d", y[0], y[1], y[2], y[3], lat, jc);
  endtask

  task automatic test_reuse();
    logic [19:0][7:0] w;
    logic [3:0][15:0] y;
    logic [3:0] lastv;
    int nw, lat, jc;
    bit st, crb, tmo;
    logic [15:0] exp_y [4];
    for (int i = 0; i < 20; i++) w[i] = 8'h55;
    w[0] = 8'd1; w[1] = 8'd0; w[2] = 8'd0; w[3] = 8'd0;
    exp_y = '{16'd1, 16'd5, 16'd9, 16'd13};
    do_job(1'b1, w, 0, 0, y, lastv, nw, lat, jc, st, crb, tmo);
    cmp_cnt++;
    if (tmo) begin bad_cnt++; $display("FAIL reuse_timeout: job did not complete"); end
    cmp_cnt++;
    if (nw !== 4) begin bad_cnt++; $display("FAIL reuse_words: got %0d need 4", nw); end
    for (int i = 0; i < 4; i++) begin
      cmp_cnt++;
      if (y[i] !== exp_y[i]) begin
        bad_cnt++;
        $display("FAIL reuse_y%0d: got %0d need %0d", i, y[i], exp_y[i]);
      end
    end
    cmp_cnt++;
    if (jc !== 31) begin bad_cnt++; $display("FAIL reuse_job_cycles: got %0d need 31", jc); end
    $display("test_reuse: words=%0d y=%0d,%0d,%0d,%0d", nw, y[0], y[1], y[2], y[3]);
  endtask

  task automatic test_signed();
    logic [19:0][7:0] w;
    logic [3:0][15:0] y;
    logic [3:0] lastv;
    int nw, lat, jc;
    bit st, crb, tmo;
    for (int i = 0; i < 16; i++) w[i] = 8'hFF;
    for (int i = 16; i < 20; i++) w[i] = 8'h7F;
    do_job(1'b0, w, 0, 0, y, lastv, nw, lat, jc, st, crb, tmo);
    cmp_cnt++;
    if (tmo) begin bad_cnt++; $display("FAIL signed_timeout: job did not complete"); end
    for (int i = 0; i < 4; i++) begin
      cmp_cnt++;
      if (y[i] !== 16'hFE04) begin
        bad_cnt++;
        $display("FAIL signed_y%0d: got %h need fe04", i, y[i]);
      end
    end
    $display("test_signed: y=%h,%h,%h,%h", y[0], y[1], y[2], y[3]);
  endtask

  task automatic test_backpressure();
    logic [19:0][7:0] w;
    logic [3:0][15:0] y;
    logic [3:0] lastv;
    int nw, lat, jc;
    bit st, crb, tmo;
    logic [15:0] exp_y [4];
    for (int i = 0; i < 16; i++) w[i] = 8'(i + 1);
    for (int i = 0; i < 4; i++) w[16 + i] = 8'(i + 1);
    exp_y = '{16'd30, 16'd70, 16'd110, 16'd150};
    do_job(1'b0, w, 35, 1, y, lastv, nw, lat, jc, st, crb, tmo);
    cmp_cnt++;
    if (tmo) begin bad_cnt++; $display("FAIL bp_timeout: job did not complete"); end
    for (int i = 0; i < 4; i++) begin
      cmp_cnt++;
      if (y[i] !== exp_y[i]) begin
        bad_cnt++;
        $display("FAIL bp_y%0d: got %0d need %0d", i, y[i], exp_y[i]);
      end
    end
    cmp_cnt++;
    if (!st) begin bad_cnt++; $display("FAIL bp_stable: data_out changed while stalled, need stable"); end
    cmp_cnt++;
    if (lastv !== 4'b1000) begin bad_cnt++; $display("FAIL bp_last: got %b need 1000", lastv); end
    cmp_cnt++;
    if (nw !== 20) begin bad_cnt++; $display("FAIL bp_words: got %0d need 20", nw); end
    $display("test_backpressure: y=%0d,%0d,%0d,%0d cycles=%0d", y[0], y[1], y[2], y[3], jc);
  endtask

  task automatic test_wrap_toggle();
    logic [19:0][7:0] w;
    logic [3:0][15:0] y;
    logic [3:0] lastv;
    int nw, lat, jc;
    bit st, crb, tmo;
    for (int i = 0; i < 16; i++) w[i] = 8'h80;
    for (int i = 16; i < 20; i++) w[i] = 8'h7F;
    do_job(1'b0, w, 0, 2, y, lastv, nw, lat, jc, st, crb, tmo);
    cmp_cnt++;
    if (tmo) begin bad_cnt++; $display("FAIL wrap_timeout: job did not complete"); end
    for (int i = 0; i < 4; i++) begin
      cmp_cnt++;
      if (y[i] !== 16'h0200) begin
        bad_cnt++;
        $display("FAIL wrap_y%0d: got %h need 0200", i, y[i]);
      end
    end
    cmp_cnt++;
    if (!st) begin bad_cnt++; $display("FAIL wrap_stable: data_out changed while stalled, need stable"); end
    $display("test_wrap_toggle: y=%h,%h,%h,%h", y[0], y[1], y[2], y[3]);
  endtask

  task automatic test_reset_mid_mac();
    logic [19:0][7:0] w;
    logic [3:0][15:0] y;
    logic [3:0] lastv;
    int nw, lat, jc;
    bit st, crb, tmo, ok;
    logic [15:0] exp_y [4];
    for (int i = 0; i < 16; i++) w[i] = 8'(i + 1);
    for (int i = 0; i < 4; i++) w[16 + i] = 8'(i + 1);
    exp_y = '{16'd30, 16'd70, 16'd110, 16'd150};
    @(negedge clk);
    hs.cmd_valid = 1'b1; hs.cmd_reuse_a = 1'b0; hs.in_valid = 1'b0; hs.out_ready = 1'b1;
    #1;
    cmp_cnt++;
    if (hs.cmd_ready !== 1'b1) begin bad_cnt++; $display("FAIL mid_cmd_ready: got %b need 1", hs.cmd_ready); end
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      hs.cmd_valid = 1'b0; hs.in_valid = 1'b1; data_in = w[i];
      #1;
      if (hs.in_ready !== 1'b1) ok = 1'b0;
    end
    @(negedge clk);
    hs.in_valid = 1'b0;
    cmp_cnt++;
    if (!ok) begin bad_cnt++; $display("FAIL mid_load_ready: in_ready dropped during load, need 1"); end
    for (int i = 1; i < 12; i++) @(negedge clk);
    #1;
    cmp_cnt++;
    if (addr_a !== 4'd9 || addr_x !== 2'd1 || clear_acc !== 1'b0) begin
      bad_cnt++;
      $display("FAIL mid_row2_addr: addr_a=%0d addr_x=%0d clear=%b need 9 1 0", addr_a, addr_x, clear_acc);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    cmp_cnt++;
    if (hs.cmd_ready !== 1'b1 || {hs.in_ready, hs.out_valid, hs.out_last, busy, clear_acc,
        wr_en_a, wr_en_x, wr_en_y, addr_a, addr_x, addr_y} !== '0) begin
      bad_cnt++;
      $display("FAIL mid_reset_idle: cmd_ready=%b busy=%b addr_a=%0d need cmd_ready 1, rest 0",
               hs.cmd_ready, busy, addr_a);
    end
    do_job(1'b1, w, 0, 0, y, lastv, nw, lat, jc, st, crb, tmo);
    cmp_cnt++;
    if (tmo) begin bad_cnt++; $display("FAIL post_reset_timeout: job did not complete"); end
    cmp_cnt++;
    if (nw !== 20) begin bad_cnt++; $display("FAIL post_reset_words: got %0d need 20", nw); end
    for (int i = 0; i < 4; i++) begin
      cmp_cnt++;
      if (y[i] !== exp_y[i]) begin
        bad_cnt++;
        $display("FAIL post_reset_y%0d: got %0d need %0d", i, y[i], exp_y[i]);
      end
    end
    $display("test_reset_mid_mac: words after reset=%0d y=%0d,%0d,%0d,%0d", nw, y[0], y[1], y[2], y[3]);
  endtask

  task automatic test_g1();
    int n0, t_last, t_first, t_wy, nacc, nwy, nclr, guard, jc;
    bit done, first_seen;
    nacc = 0; nwy = 0; nclr = 0; t_last = 0; t_first = 0; t_wy = 0; jc = -1;
    done = 1'b0; first_seen = 1'b0;
    @(negedge clk);
    hs1.cmd_valid = 1'b1; hs1.cmd_reuse_a = 1'b0; hs1.in_valid = 1'b0; hs1.out_ready = 1'b1;
    #1;
    cmp_cnt++;
    if (hs1.cmd_ready !== 1'b1) begin bad_cnt++; $display("FAIL g1_cmd_ready: got %b need 1", hs1.cmd_ready); end
    n0 = cyc_cnt;
    guard = 0;
    while (!done && guard < 200) begin
      @(negedge clk);
      guard++;
      hs1.cmd_valid = 1'b0;
      hs1.in_valid  = (nacc < 20);
      #1;
      if (hs1.in_valid && hs1.in_ready) begin nacc++; t_last = cyc_cnt; end
      if (clear_acc_g1) nclr++;
      if (wr_en_y_g1) begin nwy++; t_wy = cyc_cnt; end
      if (hs1.out_valid) begin
        if (!first_seen) begin first_seen = 1'b1; t_first = cyc_cnt; end
        if (hs1.out_last) begin done = 1'b1; jc = cyc_cnt - n0 + 1; end
      end
    end
    cmp_cnt++;
    if (!done) begin bad_cnt++; $display("FAIL g1_timeout: job did not complete"); end
    cmp_cnt++;
    if (t_first - t_last !== 27) begin bad_cnt++; $display("FAIL g1_latency: got %0d need 27", t_first - t_last); end
    cmp_cnt++;
    if (t_wy - t_last !== 25) begin bad_cnt++; $display("FAIL g1_mac_phase: got %0d need 25", t_wy - t_last); end
    cmp_cnt++;
    if (nclr !== 4 || nwy !== 4) begin
      bad_cnt++;
      $display("FAIL g1_pulses: clear=%0d wr_y=%0d need 4 4", nclr, nwy);
    end
    cmp_cnt++;
    if (jc !== 51) begin bad_cnt++; $display("FAIL g1_job_cycles: got %0d need 51", jc); end
    $display("test_g1: latency=%0d mac_phase=%0d cycles=%0d", t_first - t_last, t_wy - t_last, jc);
  endtask

  initial begin
    hs.cmd_valid = 1'b0;  hs.cmd_reuse_a = 1'b0;  hs.in_valid = 1'b0;  hs.out_ready = 1'b0;
    hs1.cmd_valid = 1'b0; hs1.cmd_reuse_a = 1'b0; hs1.in_valid = 1'b0; hs1.out_ready = 1'b0;
    data_in = 8'h00;
    test_reset();
    test_identity();
    test_reuse();
    test_signed();
    test_backpressure();
    test_wrap_toggle();
    test_reset_mid_mac();
    test_g1();
    $display("test done: total=%0d bad=%0d", cmp_cnt, bad_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
